loco_frame_ctrl: RTL

//  Frame sequencer between the UART byte receiver and the LOCO-I encoder core in loco_top.

---
 rtl/loco_frame_ctrl_if.sv | 34 +++
 rtl/loco_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/loco_frame_ctrl_if.sv
`timescale 1ns/1ps
// loco_frame_ctrl_if
// Byte-in / pixel-out bundle of the LOCO-I frame sequencer.
//   rx_valid, rx_data        : received byte strobe and value (UART side)
//   pix_valid, pix_data      : FIFO head presented to the encoder
//   pix_sof, pix_eol, pix_eof: head tags (first pixel, row end, frame end)
//   pix_ready                : encoder accepts the head
//   enc_flush, enc_abort     : one-cycle commands to the encoder
//   enc_done                 : encoder finished its flush
// modport master : the frame controller
// modport slave  : the byte source / encoder side
interface loco_frame_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_sof;
  logic       pix_eol;
  logic       pix_eof;
  logic       pix_ready;
  logic       enc_flush;
  logic       enc_done;
  logic       enc_abort;

  modport master (
    input  rx_valid, rx_data, pix_ready, enc_done,
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, enc_flush, enc_abort
  );

  modport slave (
    output rx_valid, rx_data, pix_ready, enc_done,
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof, enc_flush, enc_abort
  );
endinterface

// File: rtl/loco_frame_ctrl.sv
`timescale 1ns/1ps
// loco_frame_ctrl
// Frame sequencer between the UART byte receiver and the LOCO-I encoder.
// Counts the raw pixels of a WIDTH x HEIGHT frame, buffers them in a small
// skid FIFO tagged with sof/eol/eof, requests an encoder flush at the end of
// the frame and aborts the frame after TIMEOUT idle clocks while receiving.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (master)   : byte input, tagged pixel output, encoder flush/abort/done
//   err_clr_i      : clears both sticky error flags (a set in the same cycle wins)
//   busy_o         : controller is not idle
//   frame_done_o   : one-cycle pulse when the encoder confirms the flush
//   err_timeout_o  : sticky, frame aborted by inter-byte timeout
//   err_overrun_o  : sticky, a received byte was dropped
module loco_frame_ctrl #(
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  loco_frame_ctrl_if.master bus,
  input  logic              err_clr_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_timeout_o,
  output logic              err_overrun_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT    = {TW{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DRAIN, S_FLUSH, S_ABORT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;
  // FIFO word: {sof, eol, eof, byte}
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [10:0]     head;

  logic push, pop, at_sof, at_eol, at_eof;
  logic flush_fifo, to_set, enc_flush, enc_abort, frame_done;

  // Space is judged on the registered count only: a same-cycle pop does not
  // make room, which keeps the accept path free of pix_ready.
  assign push   = bus.rx_valid && (state_q == S_IDLE || state_q == S_RECV)
                  && (cnt_q < DEPTH_C);
  assign pop    = (cnt_q != '0) && bus.pix_ready;
  assign at_sof = (col_q == '0) && (row_q == '0);
  assign at_eol = (col_q == COL_LAST);
  assign at_eof = at_eol && (row_q == ROW_LAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    flush_fifo = 1'b0;
    to_set     = 1'b0;
    enc_flush  = 1'b0;
    enc_abort  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (push) state_d = at_eof ? S_DRAIN : S_RECV;
      end
      S_RECV: begin
        // An eof push beats a simultaneous timeout expiry.
        if (push) begin
          if (at_eof) state_d = S_DRAIN;
        end else if (timer_q == T_LAST) begin
          state_d = S_ABORT;
          to_set  = 1'b1;
        end else if (timer_q != T_SAT) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      S_DRAIN: begin
        // Empty FIFO means no pop can still be pending.
        if (cnt_q == '0) begin
          enc_flush = 1'b1;
          state_d   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.enc_done) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_ABORT: begin
        enc_abort  = 1'b1;
        flush_fifo = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_fifo) begin
      col_d    = '0;
      row_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (at_eol) begin
          col_d = '0;
          row_d = at_eof ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    err_ov_d = (bus.rx_valid && !push) ? 1'b1 : (err_clr_i ? 1'b0 : err_ov_q);
    err_to_d = to_set ? 1'b1 : (err_clr_i ? 1'b0 : err_to_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  // Storage is data only; validity comes from cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {at_sof, at_eol, at_eof, bus.rx_data};
  end

  // Head fields are forced to zero when empty so stale storage never shows.
  assign head          = mem_q[rd_ptr_q];
  assign bus.pix_valid = (cnt_q != '0);
  assign bus.pix_data  = bus.pix_valid ? head[7:0] : 8'h00;
  assign bus.pix_sof   = bus.pix_valid & head[10];
  assign bus.pix_eol   = bus.pix_valid & head[9];
  assign bus.pix_eof   = bus.pix_valid & head[8];
  assign bus.enc_flush = enc_flush;
  assign bus.enc_abort = enc_abort;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_done_o  = frame_done;
  assign err_timeout_o = err_to_q;
  assign err_overrun_o = err_ov_q;

endmodule
